// File: rtl/xh_chi_rsp_link_rx.sv
// ---------------------------------------------------------------------------
// xh_chi_rsp_link_rx
// CHI link-layer receiver for the RSP channel. It runs the receive-side link
// activation handshake. It grants L-credits only while there is free buffer
// space for them. Incoming flits go into a small circular FIFO; LCrdReturn
// flits (opcode 0) are dropped there. The FIFO head is presented to the
// requester over a valid/ready port.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   rx_linkactivereq   link activate request from the transmitter
//   rx_linkactiveack   registered link activate acknowledge
//   rx_flitpend        flit-pending hint (not used)
//   rx_flitv, rx_flit  incoming flit valid / payload
//   rx_lcrdv           L-credit grant, one credit per high cycle
//   out_valid,
//   out_ready,
//   out_flit           FIFO head presented downstream
//   credits_out        credits granted but not yet consumed
//   err_proto          sticky protocol-error flag
//
// Handshake: a flit leaves the FIFO on every rising clock edge at which
// out_valid and out_ready are both 1. out_valid and out_flit stay stable
// until that happens. out_valid does not depend on out_ready.
// ---------------------------------------------------------------------------
module xh_chi_rsp_link_rx #(
  parameter int FLIT_W      = 55,
  parameter int DEPTH       = 8,
  parameter int MAX_CREDITS = 15,
  parameter int OPC_LSB     = 26,
  parameter int OPC_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_linkactivereq,
  output logic              rx_linkactiveack,
  input  logic              rx_flitpend,
  input  logic              rx_flitv,
  input  logic [FLIT_W-1:0] rx_flit,
  output logic              rx_lcrdv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic [3:0]        credits_out,
  output logic              err_proto
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_ACT   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DEACT = 2'd3
  } link_state_t;

  link_state_t       state;
  link_state_t       state_next;
  logic [3:0]        credits_q;
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [FLIT_W-1:0] mem [DEPTH];

  logic              grant;
  logic              proto_err;
  logic              consume;
  logic              enq;
  logic              pop;
  logic [4:0]        committed;

  // The flit-pending hint carries no information this receiver needs.
  logic              unused_flitpend;
  assign unused_flitpend = rx_flitpend;

  // Outstanding credits plus buffered flits. Keeping this below DEPTH means
  // every credit already has a FIFO slot reserved for it, so the FIFO can
  // never overflow.
  assign committed = 5'(credits_q) + 5'(count_q);

  always_comb begin
    grant     = 1'b0;
    proto_err = 1'b0;
    consume   = 1'b0;
    enq       = 1'b0;
    pop       = 1'b0;
    grant     = (state == ST_RUN) && rx_linkactivereq &&
                (credits_q < 4'(MAX_CREDITS)) && (committed < 5'(DEPTH));
    // A flit without a credit to spend, or any flit while stopped, is dropped.
    proto_err = rx_flitv && ((credits_q == 4'd0) || (state == ST_STOP));
    consume   = rx_flitv && !proto_err;
    enq       = consume && (rx_flit[OPC_LSB +: OPC_W] != '0);
    pop       = out_valid && out_ready;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_STOP:  if (rx_linkactivereq) state_next = ST_ACT;
      ST_ACT:   state_next = rx_linkactivereq ? ST_RUN : ST_DEACT;
      ST_RUN:   if (!rx_linkactivereq) state_next = ST_DEACT;
      // A credit pulse still on the wire must be returned before stopping.
      ST_DEACT: if ((credits_q == 4'd0) && !rx_lcrdv) state_next = ST_STOP;
      default:  state_next = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_STOP;
      rx_linkactiveack <= 1'b0;
      rx_lcrdv         <= 1'b0;
      credits_q        <= 4'd0;
      count_q          <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      err_proto        <= 1'b0;
    end else begin
      state            <= state_next;
      rx_linkactiveack <= (state_next != ST_STOP);
      rx_lcrdv         <= grant;
      // A credit counts as outstanding from the edge that raises rx_lcrdv.
      credits_q        <= credits_q + 4'(grant) - 4'(consume);
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      err_proto <= err_proto | proto_err;
    end
  end

  // Storage needs no reset: out_flit is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= rx_flit;
  end

  assign out_valid   = (count_q != '0);
  assign out_flit    = out_valid ? mem[rd_ptr] : '0;
  assign credits_out = credits_q;

endmodule

// File: tb/tb_xh_chi_rsp_link_rx.sv
// ---------------------------------------------------------------------------
// tb_xh_chi_rsp_link_rx
// Self-checking bench for xh_chi_rsp_link_rx. Inputs change 1 time unit after
// the rising edge. Outputs are sampled on the falling edge.
// The reference model keeps a credit count, a flit count, an error flag and
// an expected-flit queue. A monitor pops that queue whenever the DUT hands a
// flit downstream.
// ---------------------------------------------------------------------------
module tb_xh_chi_rsp_link_rx;

  localparam int FLIT_W      = 55;
  localparam int DEPTH       = 8;
  localparam int MAX_CREDITS = 15;
  localparam int OPC_LSB     = 26;
  localparam int OPC_W       = 4;

  // clock / reset
  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              ack;
  logic              flitpend;
  logic              flitv;
  logic [FLIT_W-1:0] flit;
  logic              lcrdv;
  logic              out_valid;
  logic              out_ready;
  logic [FLIT_W-1:0] out_flit;
  logic [3:0]        credits_out;
  logic              err_proto;

  always #5 clk = ~clk;

  xh_chi_rsp_link_rx #(
    .FLIT_W(FLIT_W), .DEPTH(DEPTH), .MAX_CREDITS(MAX_CREDITS),
    .OPC_LSB(OPC_LSB), .OPC_W(OPC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_linkactivereq(req), .rx_linkactiveack(ack),
    .rx_flitpend(flitpend), .rx_flitv(flitv), .rx_flit(flit),
    .rx_lcrdv(lcrdv),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .credits_out(credits_out), .err_proto(err_proto)
  );

  // scoreboard state
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [FLIT_W-1:0] exp_q[$];
  logic              m_valid  = 1'b0;
  int                m_cr     = 0;
  int                m_cnt    = 0;
  logic              m_err    = 1'b0;
  logic              pv_ok    = 1'b0;
  int                n_lcrdv  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, evaluated once per cycle. Credits arrive with each
  // rx_lcrdv pulse. A grant is legal only if, in the previous cycle, the
  // transmitter was requesting and buffer room existed.
  always @(negedge clk) begin
    logic pop_m;
    if (m_valid) begin
      if (lcrdv) begin
        m_cr++;
        n_lcrdv++;
        chk("lcrdv_legal", pv_ok, 1);
      end
      chk("credits_out", credits_out, m_cr);
      chk("out_valid", out_valid, m_cnt != 0);
      chk("err_proto", err_proto, m_err);
    end
    if (rst) begin
      m_valid = 1'b1;
      m_cr    = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
      pv_ok   = 1'b0;
      exp_q.delete();
    end else if (m_valid) begin
      pv_ok = req && (m_cr < MAX_CREDITS) && ((m_cr + m_cnt) < DEPTH);
      pop_m = (m_cnt != 0) && out_ready;
      if (flitv) begin
        if (m_cr == 0) m_err = 1'b1;
        else begin
          m_cr--;
          if (flit[OPC_LSB +: OPC_W] != '0) begin
            m_cnt++;
            exp_q.push_back(flit);
          end
        end
      end
      if (pop_m) m_cnt--;
    end
  end

  // Monitor: every accepted output flit must be the oldest expected one.
  always @(negedge clk) begin
    if (m_valid && !rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected actual=%0h expected=none at %0t", out_flit, $time);
      end else begin
        chk("out_flit", out_flit, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [OPC_W-1:0] opc);
    logic [63:0]       r;
    logic [FLIT_W-1:0] f;
    r = {$urandom, $urandom};
    f = r[FLIT_W-1:0];
    f[OPC_LSB +: OPC_W] = opc;
    return f;
  endfunction

  task automatic send(input logic [OPC_W-1:0] opc);
    cyc();
    flitv = 1'b1;
    flit  = mk_flit(opc);
  endtask

  int base;

  initial begin
    rst = 1'b1; req = 1'b0; flitpend = 1'b0; flitv = 1'b0; flit = '0; out_ready = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_lcrdv", lcrdv, 0);
    chk("rst_credits", credits_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_err", err_proto, 0);

    // Activation: ack at t+1, eight credits at t+3..t+10, then silence.
    cyc(); req = 1'b1;
    @(negedge clk); chk("act_ack_t0", ack, 0);
    cyc(); @(negedge clk); chk("act_ack_t1", ack, 1);
    cyc(); @(negedge clk); chk("act_lcrdv_t2", lcrdv, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(); @(negedge clk); chk("act_lcrdv_burst", lcrdv, 1);
    end
    cyc(); @(negedge clk);
    chk("act_lcrdv_stop", lcrdv, 0);
    chk("act_credits", credits_out, 8);
    repeat (4) cyc();
    @(negedge clk); chk("act_lcrdv_idle", lcrdv, 0);

    // Three flits back-to-back: data in order, three credits refilled.
    cyc(); base = n_lcrdv;
    for (int i = 0; i < 3; i++) begin
      send(4'd4);
      if (i == 1) begin
        @(negedge clk); chk("lat_out_valid", out_valid, 1);
      end
    end
    cyc(); flitv = 1'b0;
    repeat (10) cyc();
    chk("refill_pulses", n_lcrdv - base, 3);
    @(negedge clk); chk("refill_credits", credits_out, 8);

    // Fill the FIFO with out_ready low: no grants; one pop gives one credit.
    out_ready = 1'b0;
    cyc(); base = n_lcrdv;
    for (int i = 0; i < 8; i++) send(4'($urandom_range(1, 15)));
    cyc(); flitv = 1'b0;
    repeat (5) cyc();
    chk("full_no_pulse", n_lcrdv - base, 0);
    @(negedge clk);
    chk("full_credits", credits_out, 0);
    chk("full_out_valid", out_valid, 1);
    cyc(); out_ready = 1'b1; base = n_lcrdv;
    cyc(); out_ready = 1'b0;
    @(negedge clk); chk("pop_lcrdv_t1", lcrdv, 0);
    cyc(); @(negedge clk); chk("pop_lcrdv_t2", lcrdv, 1);
    repeat (5) cyc();
    chk("pop_one_pulse", n_lcrdv - base, 1);
    out_ready = 1'b1;
    repeat (15) cyc();
    @(negedge clk); chk("drain_credits", credits_out, 8);

    // Deactivate and return all credits with LCrdReturn flits.
    cyc(); req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(4'd0);
      @(negedge clk); chk("deact_ack_held", ack, 1);
    end
    cyc(); flitv = 1'b0;
    @(negedge clk);
    chk("deact_credits", credits_out, 0);
    chk("deact_ack_last", ack, 1);
    cyc(); @(negedge clk); chk("deact_stop_ack", ack, 0);

    // Flit while stopped.
    send(4'd4);
    cyc(); flitv = 1'b0;
    @(negedge clk);
    chk("err_stop", err_proto, 1);
    chk("err_stop_valid", out_valid, 0);
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk); chk("err_cleared", err_proto, 0);

    // Flit with zero credits while running.
    out_ready = 1'b0; req = 1'b1;
    repeat (12) cyc();
    @(negedge clk); chk("run_credits", credits_out, 8);
    for (int i = 0; i < 8; i++) send(4'($urandom_range(1, 15)));
    send(4'd5);
    cyc(); flitv = 1'b0;
    @(negedge clk);
    chk("err_nocredit", err_proto, 1);
    chk("err_nocredit_credits", credits_out, 0);
    out_ready = 1'b1;
    repeat (15) cyc();
    chk("err_drop_queue", exp_q.size(), 0);

    // Reset with four flits buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd9);
    cyc(); flitv = 1'b0;
    cyc(); rst = 1'b1; req = 1'b0;
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_lcrdv", lcrdv, 0);
    chk("mid_rst_credits", credits_out, 0);
    chk("mid_rst_err", err_proto, 0);

    // Randomized traffic, with occasional link toggles.
    req = 1'b1;
    for (int i = 0; i < 500; i++) begin
      cyc();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) req = ~req;
      if (m_cr > 0 && $urandom_range(0, 2) != 0) begin
        flitv = 1'b1;
        flit  = mk_flit(($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
      end else begin
        flitv = 1'b0;
      end
    end

    // Wind down: return every credit, drain, and expect the link to stop.
    req = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      flitv = (m_cr > 0);
      flit  = mk_flit(4'd0);
    end
    cyc(); flitv = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("end_ack", ack, 0);
    chk("end_credits", credits_out, 0);
    chk("end_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
